// File: rtl/pc_call_stack_if.sv
// Request/status bundle between control decode and the pc_call_stack program counter.
interface pc_call_stack_if #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned STACK_DEPTH = 8
);
    localparam int unsigned SP_W = $clog2(STACK_DEPTH + 1);

    logic                  load;
    logic                  incr;
    logic                  call;
    logic                  ret;
    logic                  clr_flags;
    logic [DATA_WIDTH-1:0] pc_in;
    logic [DATA_WIDTH-1:0] pc_out;
    logic [DATA_WIDTH-1:0] tos_out;
    logic [SP_W-1:0]       sp_out;
    logic                  stack_empty;
    logic                  stack_full;
    logic                  ovf;
    logic                  udf;

    modport master (
        output load, incr, call, ret, clr_flags, pc_in,
        input  pc_out, tos_out, sp_out, stack_empty, stack_full, ovf, udf
    );

    modport slave (
        input  load, incr, call, ret, clr_flags, pc_in,
        output pc_out, tos_out, sp_out, stack_empty, stack_full, ovf, udf
    );
endinterface

// File: rtl/pc_call_stack.sv
// Hack CPU program counter with hardware call/return LIFO and sticky ovf/udf status.
// Optional macro PC_FAULT_TRAP_EN: faulting call/ret also vectors pc_out to TRAP_ADDR.
module pc_call_stack #(
    parameter int unsigned          DATA_WIDTH  = 16,
    parameter int unsigned          STACK_DEPTH = 8,
    parameter logic [DATA_WIDTH-1:0] TRAP_ADDR  = '0
) (
    input  logic             clk,
    input  logic             rst,
    pc_call_stack_if.slave   bus
);
    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(STACK_DEPTH);

`ifdef PC_FAULT_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] stack_q [STACK_DEPTH];

    logic [DATA_WIDTH-1:0] pc_q,  pc_nxt;
    logic [DATA_WIDTH-1:0] tos_q, tos_nxt;
    logic [SP_W-1:0]       sp_q,  sp_nxt;
    logic                  empty_q, full_q;
    logic                  ovf_q, ovf_nxt;
    logic                  udf_q, udf_nxt;
    logic                  push_c;
    logic [DATA_WIDTH-1:0] ret_addr_c;

    assign ret_addr_c = pc_q + DATA_WIDTH'(1);

    // Next-state: priority ret > call > load > incr > hold; tos tracked alongside sp.
    always_comb begin
        pc_nxt  = pc_q;
        sp_nxt  = sp_q;
        tos_nxt = tos_q;
        ovf_nxt = ovf_q & ~bus.clr_flags;
        udf_nxt = udf_q & ~bus.clr_flags;
        push_c  = 1'b0;

        if (bus.ret) begin
            if (empty_q) begin
                udf_nxt = 1'b1;
                if (TRAP_EN) pc_nxt = TRAP_ADDR;
            end else begin
                pc_nxt = tos_q;
                sp_nxt = sp_q - SP_W'(1);
                if (sp_q >= SP_W'(2)) tos_nxt = stack_q[IDX_W'(sp_q - SP_W'(2))];
                else                  tos_nxt = '0;
            end
        end else if (bus.call) begin
            pc_nxt = bus.pc_in;
            if (full_q) begin
                ovf_nxt = 1'b1;
                if (TRAP_EN) pc_nxt = TRAP_ADDR;
            end else begin
                push_c  = 1'b1;
                sp_nxt  = sp_q + SP_W'(1);
                tos_nxt = ret_addr_c;
            end
        end else if (bus.load) begin
            pc_nxt = bus.pc_in;
        end else if (bus.incr) begin
            pc_nxt = ret_addr_c;
        end
    end

    // Control/status registers; reset overrides every request.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            sp_q    <= '0;
            tos_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_nxt;
            sp_q    <= sp_nxt;
            tos_q   <= tos_nxt;
            empty_q <= (sp_nxt == '0);
            full_q  <= (sp_nxt == SP_W'(STACK_DEPTH));
            ovf_q   <= ovf_nxt;
            udf_q   <= udf_nxt;
        end
    end

    // Return-address storage: no reset, written only on a successful push.
    always_ff @(posedge clk) begin
        if (!rst && push_c) begin
            stack_q[IDX_W'(sp_q)] <= ret_addr_c;
        end
    end

    assign bus.pc_out      = pc_q;
    assign bus.tos_out     = tos_q;
    assign bus.sp_out      = sp_q;
    assign bus.stack_empty = empty_q;
    assign bus.stack_full  = full_q;
    assign bus.ovf         = ovf_q;
    assign bus.udf         = udf_q;

endmodule

// File: doc/pc_call_stack.md
Name: pc_call_stack

Overview:
- Parametrised next-generation program counter for the Hack CPU fetch path.
- Supports reset, jump-load, increment and hold, plus hardware call/return through an internal LIFO return-address stack.
- Sits between the control/jump decode logic and the instruction ROM address port.
- Lets the CPU do subroutine call/return without RAM stack traffic; provides sticky overflow/underflow status to the control unit.

Parameters:
- DATA_WIDTH, 16, width of pc_in, pc_out and each stack entry.
- STACK_DEPTH, 8, number of return-address entries; legal range 2..64.
- TRAP_ADDR, 0, fault vector; used only when PC_FAULT_TRAP_EN is defined.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  jump: pc_out <= pc_in.
- incr  input  1  pc_out <= pc_out + 1.
- call  input  1  push pc_out+1, then pc_out <= pc_in.
- ret  input  1  pop top-of-stack into pc_out.
- clr_flags  input  1  clears sticky ovf/udf.
- pc_in  input  DATA_WIDTH  jump/call target.
- pc_out  output  DATA_WIDTH  current program counter (registered).
- tos_out  output  DATA_WIDTH  top-of-stack peek; 0 when empty.
- sp_out  output  $clog2(STACK_DEPTH+1)  current entry count.
- stack_empty  output  1  sp_out == 0.
- stack_full  output  1  sp_out == STACK_DEPTH.
- ovf  output  1  sticky: call attempted while full.
- udf  output  1  sticky: ret attempted while empty.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset (rst=1 at a rising edge; overrides all other inputs):
  - pc_out=0, sp_out=0, ovf=0, udf=0, tos_out=0, stack_empty=1, stack_full=0.
  - Stack contents need no clearing. tos_out must read 0 while empty regardless of contents.
- Latency: all effects are visible the cycle after the edge. No combinational path from inputs to pc_out or sp_out.
- Priority, evaluated per edge: rst > ret > call > load > incr > hold.
  - Lower-priority requests in the same cycle are ignored.
  - call and ret together means ret wins; call is dropped with no flag.
- incr: pc_out <= pc_out+1, modulo 2^DATA_WIDTH, so 0xFFFF wraps to 0x0000 silently.
- load: pc_out <= pc_in. Stack is untouched.
- call, not full:
  - stack[sp] <= pc_out+1 (modulo wrap); sp <= sp+1; pc_out <= pc_in.
- call, full:
  - No push; sp unchanged; existing entries preserved; ovf <= 1.
  - pc_out <= pc_in (jump still taken).
- ret, not empty: pc_out <= stack[sp-1]; sp <= sp-1.
- ret, empty: sp unchanged; udf <= 1; pc_out holds.
- Hold (no request): all state unchanged.
- tos_out = stack[sp-1] when sp>0, else 0. Updates with sp, one cycle after push/pop.
- clr_flags clears ovf and udf. If a new fault occurs in the same cycle, the fault wins and the flag is set.
- Storage: STACK_DEPTH x DATA_WIDTH register array, written only on a successful push.

Optional Feature:
- Macro PC_FAULT_TRAP_EN.
- When defined: a call-while-full or ret-while-empty sets the flag as above, and also forces pc_out <= TRAP_ADDR on that edge, overriding the call target or hold. sp is unchanged.
- When undefined: behaviour exactly as in Behaviour. TRAP_ADDR is unused.

Test Plan:
- Reset then hold:
  - rst=1 for 2 cycles, then incr for 3 cycles -> pc_out=0 during reset, then 1, 2, 3.
  - sp_out=0, stack_empty=1, tos_out=0.
- Nested call/return:
  - At pc=0x0010: call pc_in=0x0100, then incr x2, then call pc_in=0x0200.
  - Expect sp_out=2 and tos_out=0x0103.
  - ret -> pc_out=0x0103, sp_out=1, tos_out=0x0011.
  - ret -> pc_out=0x0011, stack_empty=1.
- Overflow with STACK_DEPTH=8:
  - 8 calls -> stack_full=1.
  - 9th call pc_in=0x0AAA -> ovf=1, sp_out=8, pc_out=0x0AAA (trap build: TRAP_ADDR).
  - 8 rets return the original 8 addresses in LIFO order.
- Underflow:
  - After reset, ret -> udf=1, pc_out=0 held (trap build: TRAP_ADDR).
  - clr_flags -> udf=0.
  - clr_flags together with ret-while-empty -> udf stays 1.
- Priority and wrap:
  - load=incr=1 with pc_in=0x1234 -> pc_out=0x1234.
  - call=ret=1 with sp=1, tos_out=0x0050 -> pc_out=0x0050, sp_out=0.
  - pc=0xFFFF incr -> 0x0000.
  - call at pc=0xFFFF pushes 0x0000.
- Reset mid-operation:
  - With sp_out=3 and ovf=1, assert rst together with call -> next cycle pc_out=0, sp_out=0, ovf=0, no push.
